// File: rtl/proc_pkg.sv
// Shared opcode, state and error encodings for the processor instruction feeder.
// The feeder drives DIN/Run in place of the board switches and button.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ONES = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_NOIMM   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10
    } state_t;

    function automatic logic isLegal(input logic [2:0] op);
        return (op == OP_MV) || (op == OP_MVI) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_ONES) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM for the instruction feeder: one synchronous write port and one
// asynchronous read port, no reset (contents are undefined after power-up).
module prog_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          Clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [8:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [8:0]    o_rdata
);

    logic [8:0] r_mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/proc_instr_feeder.sv
// Instruction feeder: walks the program RAM, issuing each word to proc with a
// one-cycle Run pulse and waiting for Done before decoding the next one.
module proc_instr_feeder
    import proc_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [8:0]    prog_wdata,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic          busy,
    output logic          halted,
    output logic [1:0]    err,
    output logic [AW:0]   pc,
    output logic [7:0]    icount
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] PC_END  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PC_LAST = (AW + 1)'(DEPTH - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);

    state_t        r_state, w_stateNext;
    logic [8:0]    r_din, w_dinNext;
    logic          r_run, w_runNext;
    logic [AW:0]   r_pc, w_pcNext;
    logic [TW-1:0] r_tcnt, w_tcntNext;
    logic [7:0]    r_icount, w_icountNext;
    logic          r_halted, w_haltedNext;
    logic [1:0]    r_err, w_errNext;

    logic          w_we;
    logic          w_accept;
    logic [AW:0]   w_decPc;
    logic [8:0]    w_rdData;
    logic [8:0]    w_word;
    logic [2:0]    w_op;

    assign w_we     = prog_we && (r_state == S_IDLE);
    assign w_accept = ((r_state == S_IDLE) && start) || ((r_state == S_WAIT) && Done);
    assign w_decPc  = (r_state == S_IDLE) ? '0 : r_pc;

    prog_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .Clock  (Clock),
        .i_we   (w_we),
        .i_waddr(prog_addr),
        .i_wdata(prog_wdata),
        .i_raddr(w_decPc[AW-1:0]),
        .o_rdata(w_rdData)
    );

    // A write landing on address 0 in the start cycle must be seen by the first decode.
    assign w_word = ((r_state == S_IDLE) && w_we && (prog_addr == '0)) ? prog_wdata : w_rdData;
    assign w_op   = w_word[8:6];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_IDLE;
            r_din    <= '0;
            r_run    <= 1'b0;
            r_pc     <= '0;
            r_tcnt   <= '0;
            r_icount <= '0;
            r_halted <= 1'b0;
            r_err    <= ERR_NONE;
        end else begin
            r_state  <= w_stateNext;
            r_din    <= w_dinNext;
            r_run    <= w_runNext;
            r_pc     <= w_pcNext;
            r_tcnt   <= w_tcntNext;
            r_icount <= w_icountNext;
            r_halted <= w_haltedNext;
            r_err    <= w_errNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_dinNext    = r_din;
        w_runNext    = 1'b0;
        w_pcNext     = r_pc;
        w_tcntNext   = r_tcnt;
        w_icountNext = r_icount;
        w_haltedNext = r_halted;
        w_errNext    = r_err;

        if (w_accept) begin
            if (r_state == S_IDLE) begin
                w_haltedNext = 1'b0;
                w_errNext    = ERR_NONE;
                w_icountNext = '0;
                w_pcNext     = '0;
            end else if (r_icount != 8'hFF) begin
                w_icountNext = r_icount + 8'd1;
            end

            // Decode happens at the accepting edge so Run follows Done by one cycle.
            if ((w_decPc == PC_END) || (w_op == OP_HALT)) begin
                w_haltedNext = 1'b1;
                w_stateNext  = S_IDLE;
                w_dinNext    = '0;
            end else if (!isLegal(w_op)) begin
                w_errNext   = ERR_ILLEGAL;
                w_stateNext = S_IDLE;
                w_dinNext   = '0;
            end else if ((w_op == OP_MVI) && (w_decPc == PC_LAST)) begin
                w_errNext   = ERR_NOIMM;
                w_stateNext = S_IDLE;
                w_dinNext   = '0;
            end else begin
                w_dinNext   = w_word;
                w_runNext   = 1'b1;
                w_pcNext    = w_decPc + 1'b1;
                w_stateNext = S_ISSUE;
            end
        end else begin
            case (r_state)
                S_ISSUE: begin
                    w_stateNext = S_WAIT;
                    w_tcntNext  = '0;
                    if (r_din[8:6] == OP_MVI) begin
                        w_dinNext = w_rdData;
                        w_pcNext  = r_pc + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_tcnt == TMAX) begin
                        w_errNext   = ERR_TIMEOUT;
                        w_stateNext = S_IDLE;
                        w_dinNext   = '0;
                    end else begin
                        w_tcntNext = r_tcnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign DIN    = r_din;
    assign Run    = r_run;
    assign busy   = (r_state != S_IDLE);
    assign halted = r_halted;
    assign err    = r_err;
    assign pc     = r_pc;
    assign icount = r_icount;

endmodule
